// File: rtl/conv_psum_accum_if.sv
`default_nettype none
// ============================================================================
// Module   : conv_psum_accum_if
// Desc     : Psum input stream and ofmap output stream of conv_psum_accum.
// Revision : 1.0 - initial release
// ============================================================================
interface conv_psum_accum_if #(
    parameter int PSUM_WIDTH = 20,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
);
    logic                         psum_valid_i;
    logic signed [PSUM_WIDTH-1:0] psum_i;
    logic                         psum_ready_o;
    logic                         ofmap_valid_o;
    logic [DATA_WIDTH-1:0]        ofmap_data_o;
    logic [ADDR_WIDTH-1:0]        ofmap_addr_o;

    modport master (
        output psum_valid_i, psum_i,
        input  psum_ready_o, ofmap_valid_o, ofmap_data_o, ofmap_addr_o
    );

    modport slave (
        input  psum_valid_i, psum_i,
        output psum_ready_o, ofmap_valid_o, ofmap_data_o, ofmap_addr_o
    );
endinterface
`default_nettype wire

// File: rtl/conv_psum_accum.sv
`default_nettype none
// ============================================================================
// Module   : conv_psum_accum
// Desc     : Accumulates psums across channel passes; on the last pass emits
//            ReLU / shifted / int8-saturated ofmap pixels with their address.
// Revision : 1.0 - initial release
// ============================================================================
module conv_psum_accum #(
    parameter int PSUM_WIDTH = 20,
    parameter int ACC_WIDTH  = 24,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_DEPTH  = 784
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic [1:0]  nth_conv_i,
    input  wire logic [4:0]  ofmap_size_i,
    input  wire logic        ch_first_i,
    input  wire logic        ch_last_i,
    input  wire logic [3:0]  quant_shift_i,
    conv_psum_accum_if.slave bus,
    output logic             pass_done_o,
    output logic             conv_done_o,
    output logic             err_overrun_o
);
    localparam int ADDR_WIDTH = $clog2(ACC_DEPTH);
    localparam int c_PIX_MAX  = (1 << (DATA_WIDTH - 1)) - 1;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ACCUM = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;

    logic [1:0]                   r_state;
    logic                         r_drain_cnt;
    logic [ADDR_WIDTH-1:0]        r_pix_cnt;
    logic                         r_pass_last;
    logic                         r_s0_valid;
    logic [ADDR_WIDTH-1:0]        r_s0_addr;
    logic signed [PSUM_WIDTH-1:0] r_s0_psum;
    logic                         r_s0_first;
    logic                         r_s0_last;
    logic [3:0]                   r_s0_shift;
    logic [ACC_WIDTH-1:0]         r_rd_data;
    logic [ACC_WIDTH-1:0]         r_mem [ACC_DEPTH];
    logic                         r_ofmap_valid;
    logic [DATA_WIDTH-1:0]        r_ofmap_data;
    logic [ADDR_WIDTH-1:0]        r_ofmap_addr;
    logic                         r_pass_done;
    logic                         r_conv_done;
    logic                         r_err;

    logic [10:0]           w_pass_len;
    logic                  w_pix_last;
    logic                  w_ready;
    logic                  w_accept;
    logic                  w_first;
    logic                  w_last;
    logic                  w_fwd;
    logic [ACC_WIDTH-1:0]  w_psum_ext;
    logic [ACC_WIDTH:0]    w_sum_wide;
    logic                  w_ovf;
    logic [ACC_WIDTH-1:0]  w_acc_new;
    logic [ACC_WIDTH-1:0]  w_relu;
    logic [ACC_WIDTH-1:0]  w_shifted;
    logic [DATA_WIDTH-1:0] w_data;

    assign w_pass_len = 11'(ofmap_size_i) * 11'(ofmap_size_i);
    assign w_pix_last = (11'(r_pix_cnt) == (w_pass_len - 11'd1));
    assign w_ready    = (r_state != c_DRAIN);
    assign w_accept   = bus.psum_valid_i & w_ready;
    // conv1 is a single pass: it always both overwrites and emits
    assign w_first    = (nth_conv_i == 2'd0) | ch_first_i;
    assign w_last     = (nth_conv_i == 2'd0) | ch_last_i;

    // S1: saturating accumulate of the value read (or forwarded) in S0
    assign w_psum_ext = {{(ACC_WIDTH - PSUM_WIDTH){r_s0_psum[PSUM_WIDTH-1]}}, r_s0_psum};
    assign w_sum_wide = {r_rd_data[ACC_WIDTH-1], r_rd_data} + {w_psum_ext[ACC_WIDTH-1], w_psum_ext};
    assign w_ovf      = w_sum_wide[ACC_WIDTH] ^ w_sum_wide[ACC_WIDTH-1];
    always_comb begin
        w_acc_new = w_sum_wide[ACC_WIDTH-1:0];
        if (r_s0_first) begin
            w_acc_new = w_psum_ext;
        end else if (w_ovf) begin
            w_acc_new = w_sum_wide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                              : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
    end

    assign w_relu    = w_acc_new[ACC_WIDTH-1] ? '0 : w_acc_new;
    assign w_shifted = w_relu >> r_s0_shift;
    assign w_data    = (w_shifted > ACC_WIDTH'(c_PIX_MAX)) ? DATA_WIDTH'(c_PIX_MAX)
                                                           : w_shifted[DATA_WIDTH-1:0];

    // S1 write-back landing on the address S0 is reading this edge
    assign w_fwd = r_s0_valid & (r_s0_addr == r_pix_cnt);

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_s0_addr  <= r_pix_cnt;
            r_s0_psum  <= bus.psum_i;
            r_s0_first <= w_first;
            r_s0_last  <= w_last;
            r_s0_shift <= quant_shift_i;
            r_rd_data  <= w_fwd ? w_acc_new : r_mem[r_pix_cnt];
        end
        if (r_s0_valid && !rst) begin
            r_mem[r_s0_addr] <= w_acc_new;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_IDLE;
            r_drain_cnt   <= 1'b0;
            r_pix_cnt     <= '0;
            r_pass_last   <= 1'b0;
            r_s0_valid    <= 1'b0;
            r_ofmap_valid <= 1'b0;
            r_ofmap_data  <= '0;
            r_ofmap_addr  <= '0;
            r_pass_done   <= 1'b0;
            r_conv_done   <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_s0_valid    <= w_accept;
            r_ofmap_valid <= r_s0_valid & r_s0_last;
            if (r_s0_valid && r_s0_last) begin
                r_ofmap_data <= w_data;
                r_ofmap_addr <= r_s0_addr;
            end
            r_pass_done <= 1'b0;
            r_conv_done <= 1'b0;
            if (bus.psum_valid_i && !w_ready) begin
                r_err <= 1'b1;
            end
            case (r_state)
                c_IDLE, c_ACCUM: begin
                    if (w_accept) begin
                        r_pass_last <= w_last;
                        if (w_pix_last) begin
                            r_pix_cnt   <= '0;
                            r_drain_cnt <= 1'b0;
                            r_state     <= c_DRAIN;
                        end else begin
                            r_pix_cnt <= r_pix_cnt + ADDR_WIDTH'(1);
                            r_state   <= c_ACCUM;
                        end
                    end
                end
                c_DRAIN: begin
                    if (!r_drain_cnt) begin
                        r_drain_cnt <= 1'b1;
                        r_pass_done <= 1'b1;
                        r_conv_done <= r_pass_last;
                    end else begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign bus.psum_ready_o  = w_ready;
    assign bus.ofmap_valid_o = r_ofmap_valid;
    assign bus.ofmap_data_o  = r_ofmap_data;
    assign bus.ofmap_addr_o  = r_ofmap_addr;
    assign pass_done_o       = r_pass_done;
    assign conv_done_o       = r_conv_done;
    assign err_overrun_o     = r_err;
endmodule
`default_nettype wire

// File: tb/tb_conv_psum_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_psum_accum
// Desc     : Self-checking bench: pixel-level accumulator model + scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_psum_accum;
    localparam int  PW      = 20;
    localparam int  DEPTH   = 784;
    localparam longint ACC_MAX = 64'sd8388607;
    localparam longint ACC_MIN = -64'sd8388608;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] nth_conv = 2'd0;
    logic [4:0] ofmap_size = 5'd1;
    logic       ch_first = 1'b0;
    logic       ch_last = 1'b0;
    logic [3:0] quant_shift = 4'd0;
    logic       pass_done, conv_done, err_overrun;

    conv_psum_accum_if #(.PSUM_WIDTH(20), .DATA_WIDTH(8), .ADDR_WIDTH(10)) bus ();

    conv_psum_accum #(.PSUM_WIDTH(20), .ACC_WIDTH(24), .DATA_WIDTH(8), .ACC_DEPTH(784)) dut (
        .clk(clk), .rst(rst), .nth_conv_i(nth_conv), .ofmap_size_i(ofmap_size),
        .ch_first_i(ch_first), .ch_last_i(ch_last), .quant_shift_i(quant_shift),
        .bus(bus), .pass_done_o(pass_done), .conv_done_o(conv_done), .err_overrun_o(err_overrun)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int quant(input longint a, input int sh);
        longint r;
        r = (a < 0) ? 0 : a;
        r = r >> sh;
        return (r > 127) ? 127 : int'(r);
    endfunction

    // reference model: per-pixel accumulators, expected events keyed by due cycle
    typedef struct { longint due; int addr; int data; } out_t;
    typedef struct { longint due; bit last; } pd_t;
    longint acc_m [DEPTH];
    out_t   q_out [$];
    pd_t    q_pd  [$];
    int     m_pix = 0;
    longint busy_until = -1;
    bit     err_exp = 1'b0;
    bit     mon_en = 1'b0;
    int     n_out = 0, n_pd = 0, n_cd = 0;
    int     last_data = -1, last_addr = -1;

    task automatic model_accept(input longint p);
        int n2 = int'(ofmap_size) * int'(ofmap_size);
        bit f  = (nth_conv == 2'd0) || ch_first;
        bit l  = (nth_conv == 2'd0) || ch_last;
        longint s;
        s = f ? p : acc_m[m_pix] + p;
        if (s > ACC_MAX) s = ACC_MAX;
        if (s < ACC_MIN) s = ACC_MIN;
        acc_m[m_pix] = s;
        if (l) q_out.push_back('{cyc + 2, m_pix, quant(s, int'(quant_shift))});
        if (m_pix == n2 - 1) begin
            q_pd.push_back('{cyc + 2, l});
            busy_until = cyc + 2;
            m_pix = 0;
        end else begin
            m_pix++;
        end
    endtask

    always @(negedge clk) begin
        out_t e;
        pd_t  p;
        bit   rdy_exp;
        if (mon_en) begin
            if (bus.ofmap_valid_o) begin
                n_out++;
                last_data = int'(bus.ofmap_data_o);
                last_addr = int'(bus.ofmap_addr_o);
            end
            if (pass_done) n_pd++;
            if (conv_done) n_cd++;
            if (q_out.size() > 0 && q_out[0].due == cyc) begin
                e = q_out.pop_front();
                check("ofmap_valid", bus.ofmap_valid_o, 1);
                check("ofmap_addr", bus.ofmap_addr_o, e.addr);
                check("ofmap_data", bus.ofmap_data_o, e.data);
            end else begin
                check("ofmap_valid_quiet", bus.ofmap_valid_o, 0);
            end
            if (q_pd.size() > 0 && q_pd[0].due == cyc) begin
                p = q_pd.pop_front();
                check("pass_done", pass_done, 1);
                check("conv_done", conv_done, p.last);
            end else begin
                check("pass_done_quiet", pass_done, 0);
                check("conv_done_quiet", conv_done, 0);
            end
            rdy_exp = (cyc > busy_until);
            check("psum_ready", bus.psum_ready_o, rdy_exp);
            check("err_overrun", err_overrun, err_exp);
            if (rst) begin
                q_out.delete();
                q_pd.delete();
                m_pix = 0;
                busy_until = cyc;
                err_exp = 1'b0;
            end else begin
                if (bus.psum_valid_i && !rdy_exp) err_exp = 1'b1;
                if (bus.psum_valid_i && rdy_exp) model_accept(longint'(bus.psum_i));
            end
        end
    end

    // driver: every step starts just after a rising edge
    int pq [$];
    bit bubbles = 1'b0;

    task automatic drive_psums(input int conv, input int n, input bit f, input bit l,
                               input int sh, input int hold);
        int i = 0;
        int guard = 0;
        bit acc;
        nth_conv = 2'(conv); ofmap_size = 5'(n); ch_first = f; ch_last = l; quant_shift = 4'(sh);
        while (i < pq.size() && guard < pq.size() * 8 + 20) begin
            bus.psum_valid_i = !(bubbles && $urandom_range(3) == 0);
            bus.psum_i = PW'(pq[i]);
            @(negedge clk);
            acc = bus.psum_valid_i && bus.psum_ready_o;
            @(posedge clk); #1;
            if (acc) i++;
            guard++;
        end
        check("pass_accepts", i, pq.size());
        repeat (hold) begin
            @(negedge clk); @(posedge clk); #1;
        end
        bus.psum_valid_i = 1'b0;
    endtask

    task automatic wait_ready();
        int k = 0;
        while (k < 20) begin
            @(negedge clk);
            if (bus.psum_ready_o) break;
            @(posedge clk); #1;
            k++;
        end
        check("ready_return", bus.psum_ready_o, 1);
        @(posedge clk); #1;
    endtask

    task automatic run_pass(input int conv, input int n, input bit f, input bit l,
                            input int sh, input int hold);
        drive_psums(conv, n, f, l, sh, hold);
        wait_ready();
    endtask

    task automatic fill_const(input int n2, input int v);
        pq.delete();
        for (int k = 0; k < n2; k++) pq.push_back(v);
    endtask

    typedef struct { int psum; int shift; int exp; } vec_t;
    vec_t tv [14];

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int pd0, cd0, o0;
        tv[0]  = '{0, 0, 0};         tv[1]  = '{-5, 0, 0};       tv[2]  = '{100, 0, 100};
        tv[3]  = '{127, 0, 127};     tv[4]  = '{128, 0, 127};    tv[5]  = '{300, 1, 127};
        tv[6]  = '{300, 2, 75};      tv[7]  = '{255, 1, 127};    tv[8]  = '{254, 1, 127};
        tv[9]  = '{253, 2, 63};      tv[10] = '{524287, 15, 15}; tv[11] = '{-524288, 3, 0};
        tv[12] = '{1000, 3, 125};    tv[13] = '{1023, 3, 127};

        bus.psum_valid_i = 1'b0;
        bus.psum_i = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ofmap_valid", bus.ofmap_valid_o, 0);
        check("rst_ofmap_data", bus.ofmap_data_o, 0);
        check("rst_ofmap_addr", bus.ofmap_addr_o, 0);
        check("rst_pass_done", pass_done, 0);
        check("rst_conv_done", conv_done, 0);
        check("rst_err", err_overrun, 0);
        check("rst_ready", bus.psum_ready_o, 1);
        mon_en = 1'b1;
        @(posedge clk); #1;

        // quantisation table through single-pixel conv1 passes
        for (int v = 0; v < 14; v++) begin
            pq.delete();
            pq.push_back(tv[v].psum);
            last_data = -1;
            run_pass(0, 1, 1'b1, 1'b1, tv[v].shift, 0);
            check($sformatf("quant_vec%0d", v), last_data, tv[v].exp);
        end

        // conv1 full 28x28 ramp
        pd0 = n_pd; cd0 = n_cd; o0 = n_out;
        pq.delete();
        for (int k = 0; k < 784; k++) pq.push_back(k - 14);
        run_pass(0, 28, 1'b1, 1'b1, 0, 0);
        check("conv1_outputs", n_out - o0, 784);
        check("conv1_last_addr", last_addr, 783);
        check("conv1_last_data", last_data, 127);
        check("conv1_pass_done", n_pd - pd0, 1);
        check("conv1_conv_done", n_cd - cd0, 1);

        // conv2: 6 channel passes of 5, shift 1
        pd0 = n_pd; cd0 = n_cd; o0 = n_out;
        for (int p = 0; p < 6; p++) begin
            fill_const(100, 5);
            run_pass(1, 10, p == 0, p == 5, 1, 0);
        end
        check("conv2_outputs", n_out - o0, 100);
        check("conv2_data", last_data, 15);
        check("conv2_last_addr", last_addr, 99);
        check("conv2_pass_done", n_pd - pd0, 6);
        check("conv2_conv_done", n_cd - cd0, 1);

        // saturation at both rails, then walk back off the clamp
        for (int p = 0; p < 20; p++) begin
            fill_const(4, 524287);
            run_pass(1, 2, p == 0, p == 19, 0, 0);
        end
        check("sat_pos", last_data, 127);
        for (int p = 0; p < 15; p++) begin
            fill_const(4, -524288);
            run_pass(1, 2, 1'b0, p == 14, 15, 0);
        end
        check("sat_pos_recover", last_data, 15);
        for (int p = 0; p < 20; p++) begin
            fill_const(4, -524288);
            run_pass(1, 2, p == 0, p == 19, 0, 0);
        end
        check("sat_neg", last_data, 0);
        for (int p = 0; p < 17; p++) begin
            fill_const(4, 524287);
            run_pass(1, 2, 1'b0, p == 16, 15, 0);
        end
        check("sat_neg_recover", last_data, 15);

        // conv3: 1x1, 16 back-to-back passes
        o0 = n_out;
        for (int p = 0; p < 16; p++) begin
            fill_const(1, p);
            run_pass(2, 1, p == 0, p == 15, 0, 0);
        end
        check("conv3_outputs", n_out - o0, 1);
        check("conv3_data", last_data, 120);
        check("conv3_addr", last_addr, 0);

        // overrun: valid held through the drain window
        pq = '{10, 20, 30, 40};
        run_pass(0, 2, 1'b1, 1'b1, 0, 2);
        check("overrun_flag", err_overrun, 1);
        pq = '{1, 2, 3, 4};
        run_pass(0, 2, 1'b1, 1'b1, 0, 0);
        check("overrun_next_addr", last_addr, 3);
        check("overrun_next_data", last_data, 4);
        check("overrun_sticky", err_overrun, 1);

        // reset at pixel 40 of a 10x10 pass
        pd0 = n_pd;
        fill_const(40, 50);
        drive_psums(0, 10, 1'b1, 1'b1, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_ofmap_valid", bus.ofmap_valid_o, 0);
        check("midrst_pass_done", pass_done, 0);
        check("midrst_err", err_overrun, 0);
        repeat (5) @(posedge clk);
        #1;
        check("midrst_no_pass_done", n_pd - pd0, 0);
        o0 = n_out;
        pq.delete();
        for (int k = 0; k < 100; k++) pq.push_back(3 * k);
        run_pass(1, 10, 1'b1, 1'b1, 2, 0);
        check("midrst_fresh_outputs", n_out - o0, 100);
        check("midrst_fresh_data", last_data, 74);

        // randomized pass sequences with input bubbles
        bubbles = 1'b1;
        for (int s = 0; s < 12; s++) begin
            int conv = int'($urandom_range(2));
            int n    = (conv == 2) ? 1 : int'($urandom_range(1, 8));
            int np   = (conv == 0) ? 1 : int'($urandom_range(1, 4));
            int sh   = int'($urandom_range(0, 6));
            for (int p = 0; p < np; p++) begin
                pq.delete();
                for (int k = 0; k < n * n; k++) begin
                    if ($urandom_range(7) == 0) pq.push_back(int'($urandom_range(0, 1048575)) - 524288);
                    else pq.push_back(int'($urandom_range(0, 4000)) - 2000);
                end
                if (conv == 0) run_pass(conv, n, 1'($urandom_range(1)), 1'($urandom_range(1)), sh, 0);
                else run_pass(conv, n, p == 0, p == np - 1, sh, 0);
            end
        end
        bubbles = 1'b0;

        repeat (5) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
